// File: rtl/sd_req_arbiter.sv
// Two-client arbiter for the single hps_io virtual-disk sector channel.
// Round-robin on ties, with a watchdog that aborts requests never acknowledged.
module sd_req_arbiter #(
   parameter logic [25:0] TIMEOUT = 26'd50_000_000
) (
   input  logic        clk_sys,
   input  logic        reset,

   input  logic [31:0] c0_lba,
   input  logic        c0_rd,
   input  logic        c0_wr,
   output logic        c0_ack,
   output logic        c0_done,
   output logic        c0_err,
   input  logic [7:0]  c0_buff_din,
   output logic        c0_buff_wr,

   input  logic [31:0] c1_lba,
   input  logic        c1_rd,
   input  logic        c1_wr,
   output logic        c1_ack,
   output logic        c1_done,
   output logic        c1_err,
   input  logic [7:0]  c1_buff_din,
   output logic        c1_buff_wr,

   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   input  logic        sd_buff_wr,
   output logic [7:0]  sd_buff_din,

   output logic        busy,
   output logic        grant
);

   typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic        grant_q, grant_d;
   logic [31:0] sd_lba_q, sd_lba_d;
   logic        sd_rd_q, sd_rd_d;
   logic        sd_wr_q, sd_wr_d;
   logic [25:0] wdog_q, wdog_d;
   logic        c0_ack_q, c0_ack_d;
   logic        c1_ack_q, c1_ack_d;
   logic        c0_done_q, c0_done_d;
   logic        c1_done_q, c1_done_d;
   logic        c0_err_q, c0_err_d;
   logic        c1_err_q, c1_err_d;

   logic pend0, pend1, sel;

   assign pend0 = c0_rd | c0_wr;
   assign pend1 = c1_rd | c1_wr;
   // Tie goes to whichever client was not served last.
   assign sel   = (pend0 & pend1) ? ~last_q : pend1;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      sd_lba_d  = sd_lba_q;
      sd_rd_d   = sd_rd_q;
      sd_wr_d   = sd_wr_q;
      wdog_d    = wdog_q;
      c0_ack_d  = 1'b0;
      c1_ack_d  = 1'b0;
      c0_done_d = 1'b0;
      c1_done_d = 1'b0;
      c0_err_d  = 1'b0;
      c1_err_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A stale ack from the previous transfer blocks arbitration.
            if (!sd_ack && (pend0 || pend1)) begin
               grant_d  = sel;
               sd_lba_d = sel ? c1_lba : c0_lba;
               sd_rd_d  = sel ? c1_rd : c0_rd;
               sd_wr_d  = sel ? ~c1_rd : ~c0_rd;
               wdog_d   = '0;
               state_d  = StReq;
            end
         end
         StReq: begin
            if (sd_ack) begin
               sd_rd_d  = 1'b0;
               sd_wr_d  = 1'b0;
               c0_ack_d = ~grant_q;
               c1_ack_d = grant_q;
               state_d  = StXfer;
            end else if (wdog_q == TIMEOUT - 26'd1) begin
               sd_rd_d  = 1'b0;
               sd_wr_d  = 1'b0;
               c0_err_d = ~grant_q;
               c1_err_d = grant_q;
               last_d   = grant_q;
               state_d  = StIdle;
            end else begin
               wdog_d = wdog_q + 26'd1;
            end
         end
         StXfer: begin
            c0_ack_d = sd_ack & ~grant_q;
            c1_ack_d = sd_ack & grant_q;
            if (!sd_ack) begin
               c0_done_d = ~grant_q;
               c1_done_d = grant_q;
               state_d   = StDone;
            end
         end
         StDone: begin
            last_d  = grant_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         grant_q   <= 1'b0;
         sd_lba_q  <= '0;
         sd_rd_q   <= 1'b0;
         sd_wr_q   <= 1'b0;
         wdog_q    <= '0;
         c0_ack_q  <= 1'b0;
         c1_ack_q  <= 1'b0;
         c0_done_q <= 1'b0;
         c1_done_q <= 1'b0;
         c0_err_q  <= 1'b0;
         c1_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         sd_lba_q  <= sd_lba_d;
         sd_rd_q   <= sd_rd_d;
         sd_wr_q   <= sd_wr_d;
         wdog_q    <= wdog_d;
         c0_ack_q  <= c0_ack_d;
         c1_ack_q  <= c1_ack_d;
         c0_done_q <= c0_done_d;
         c1_done_q <= c1_done_d;
         c0_err_q  <= c0_err_d;
         c1_err_q  <= c1_err_d;
      end
   end

   assign sd_lba      = sd_lba_q;
   assign sd_rd       = sd_rd_q;
   assign sd_wr       = sd_wr_q;
   assign grant       = grant_q;
   assign busy        = (state_q != StIdle);
   assign c0_ack      = c0_ack_q;
   assign c1_ack      = c1_ack_q;
   assign c0_done     = c0_done_q;
   assign c1_done     = c1_done_q;
   assign c0_err      = c0_err_q;
   assign c1_err      = c1_err_q;
   assign c0_buff_wr  = sd_buff_wr & ~grant_q & (state_q == StXfer);
   assign c1_buff_wr  = sd_buff_wr & grant_q & (state_q == StXfer);
   assign sd_buff_din = grant_q ? c1_buff_din : c0_buff_din;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_sd_req_arbiter;

   localparam logic [31:0] Lba0 = 32'h0000_1234;
   localparam logic [31:0] Lba1 = 32'hBEEF_0001;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [31:0] c0_lba, c1_lba;
   logic        c0_rd, c0_wr, c1_rd, c1_wr;
   logic        c0_ack, c1_ack, c0_done, c1_done, c0_err, c1_err;
   logic [7:0]  c0_buff_din, c1_buff_din;
   logic        c0_buff_wr, c1_buff_wr;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
   logic [7:0]  sd_buff_din;
   logic        busy, grant;

   int errors = 0;
   int checks = 0;

   always #5 clk_sys = ~clk_sys;

   sd_req_arbiter #(.TIMEOUT(26'd16)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .c0_lba      (c0_lba),
      .c0_rd       (c0_rd),
      .c0_wr       (c0_wr),
      .c0_ack      (c0_ack),
      .c0_done     (c0_done),
      .c0_err      (c0_err),
      .c0_buff_din (c0_buff_din),
      .c0_buff_wr  (c0_buff_wr),
      .c1_lba      (c1_lba),
      .c1_rd       (c1_rd),
      .c1_wr       (c1_wr),
      .c1_ack      (c1_ack),
      .c1_done     (c1_done),
      .c1_err      (c1_err),
      .c1_buff_din (c1_buff_din),
      .c1_buff_wr  (c1_buff_wr),
      .sd_lba      (sd_lba),
      .sd_rd       (sd_rd),
      .sd_wr       (sd_wr),
      .sd_ack      (sd_ack),
      .sd_buff_wr  (sd_buff_wr),
      .sd_buff_din (sd_buff_din),
      .busy        (busy),
      .grant       (grant)
   );

   // {sd_rd, sd_wr, grant, busy, c0_ack, c1_ack, c0_done, c1_done, c0_err, c1_err,
   //  c0_buff_wr, c1_buff_wr}
   logic [11:0] obs;
   assign obs = {sd_rd, sd_wr, grant, busy, c0_ack, c1_ack, c0_done, c1_done,
                 c0_err, c1_err, c0_buff_wr, c1_buff_wr};

   // vin = {c0_rd, c0_wr, c1_rd, c1_wr, sd_ack, sd_buff_wr}
   typedef struct packed {
      logic [5:0]  vin;
      logic [11:0] vexp;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {c0_rd, c0_wr, c1_rd, c1_wr, sd_ack, sd_buff_wr} = '0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic wait_req(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (sd_rd || sd_wr) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({name, " request timeout"}, 32'd0, 32'd1);
   endtask

   // One complete transfer for client cl, with nstr sector-buffer strobes.
   task automatic xfer(input string name, input logic cl, input logic rd, input int nstr);
      bit ok;
      int own_wr, other_wr, din_bad, own_done;
      own_wr = 0; other_wr = 0; din_bad = 0; own_done = 0;
      if (cl) begin c1_rd = rd; c1_wr = ~rd; end
      else    begin c0_rd = rd; c0_wr = ~rd; end
      wait_req(name, ok);
      if (!ok) return;
      chk({name, " grant/rd/wr"}, {29'd0, grant, sd_rd, sd_wr}, {29'd0, cl, rd, ~rd});
      chk({name, " sd_lba"}, sd_lba, cl ? Lba1 : Lba0);
      sd_ack = 1'b1;
      cyc();
      if (cl) begin c1_rd = 1'b0; c1_wr = 1'b0; end
      else    begin c0_rd = 1'b0; c0_wr = 1'b0; end
      chk({name, " ack/lines"}, {29'd0, cl ? c1_ack : c0_ack, sd_rd, sd_wr}, 32'd4);
      for (int i = 0; i < nstr; i++) begin
         sd_buff_wr = 1'b1;
         #1;
         own_wr   += int'(cl ? c1_buff_wr : c0_buff_wr);
         other_wr += int'(cl ? c0_buff_wr : c1_buff_wr);
         if (sd_buff_din !== (cl ? 8'hA5 : 8'h5A)) din_bad++;
         cyc();
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         own_done += int'(cl ? c1_done : c0_done);
      end
      chk({name, " own strobes"}, own_wr, nstr);
      chk({name, " other strobes"}, other_wr, 0);
      chk({name, " sd_buff_din steering errors"}, din_bad, 0);
      chk({name, " done pulses"}, own_done, 1);
   endtask

   initial begin
      bit ok;
      int hi, bad_wr, bad_done, bad_busy;
      c0_lba = Lba0;
      c1_lba = Lba1;
      c0_buff_din = 8'h5A;
      c1_buff_din = 8'hA5;
      do_reset();
      chk("reset outputs", {20'd0, obs}, 32'd0);
      chk("reset sd_lba", sd_lba, 32'd0);

      // Read on c0, tie with last=0 goes to c1, write on c0, stale-ack holdoff.
      tbl.push_back({6'b100000, 12'b0000_0000_0000});
      tbl.push_back({6'b100000, 12'b1001_0000_0000});
      tbl.push_back({6'b100010, 12'b1001_0000_0000});
      tbl.push_back({6'b000011, 12'b0001_1000_0010});
      tbl.push_back({6'b000010, 12'b0001_1000_0000});
      tbl.push_back({6'b000000, 12'b0001_1000_0000});
      tbl.push_back({6'b000000, 12'b0001_0010_0000});
      tbl.push_back({6'b000000, 12'b0000_0000_0000});
      tbl.push_back({6'b011000, 12'b0000_0000_0000});
      tbl.push_back({6'b011000, 12'b1011_0000_0000});
      tbl.push_back({6'b011010, 12'b1011_0000_0000});
      tbl.push_back({6'b010011, 12'b0011_0100_0001});
      tbl.push_back({6'b010000, 12'b0011_0100_0000});
      tbl.push_back({6'b010000, 12'b0011_0001_0000});
      tbl.push_back({6'b010000, 12'b0010_0000_0000});
      tbl.push_back({6'b010010, 12'b0101_0000_0000});
      tbl.push_back({6'b000011, 12'b0001_1000_0010});
      tbl.push_back({6'b000000, 12'b0001_1000_0000});
      tbl.push_back({6'b000000, 12'b0001_0010_0000});
      tbl.push_back({6'b100010, 12'b0000_0000_0000});
      tbl.push_back({6'b100010, 12'b0000_0000_0000});
      tbl.push_back({6'b100000, 12'b0000_0000_0000});
      tbl.push_back({6'b100000, 12'b1001_0000_0000});

      foreach (tbl[i]) begin
         {c0_rd, c0_wr, c1_rd, c1_wr, sd_ack, sd_buff_wr} = tbl[i].vin;
         #1;
         chk($sformatf("vec %0d", i), {20'd0, obs}, {20'd0, tbl[i].vexp});
         cyc();
      end

      // Tie right after reset: c0 (write) first, then c1 (read).
      do_reset();
      c1_rd = 1'b1;
      xfer("tie c0", 1'b0, 1'b0, 2);
      xfer("tie c1", 1'b1, 1'b1, 4);

      // Full-sector read on c0, then a short c1 transfer for data steering.
      do_reset();
      xfer("sector c0", 1'b0, 1'b1, 512);
      xfer("steer c1", 1'b1, 1'b0, 8);

      // Watchdog: sd_rd must stay high for exactly TIMEOUT cycles.
      do_reset();
      c1_rd = 1'b1;
      wait_req("timeout", ok);
      c1_rd = 1'b0;
      hi = 1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (sd_rd) hi++;
         else break;
      end
      chk("timeout sd_rd high cycles", hi, 16);
      chk("timeout err/busy", {29'd0, c1_err, c0_err, busy}, 32'd4);
      cyc();
      chk("timeout err single pulse", {31'd0, c1_err}, 32'd0);
      xfer("after timeout c0", 1'b0, 1'b1, 3);

      // Reset while a transfer is in XFER.
      do_reset();
      c0_rd = 1'b1;
      wait_req("midreset", ok);
      sd_ack = 1'b1;
      cyc();
      c0_rd = 1'b0;
      sd_buff_wr = 1'b1;
      #1;
      chk("midreset pre strobe", {31'd0, c0_buff_wr}, 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("midreset outputs", {20'd0, obs}, 32'd0);
      chk("midreset sd_lba", sd_lba, 32'd0);
      bad_wr = 0; bad_done = 0; bad_busy = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         bad_wr += int'(c0_buff_wr | c1_buff_wr);
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         bad_done += int'(c0_done | c1_done);
         bad_busy += int'(busy);
      end
      chk("midreset strobes after reset", bad_wr, 0);
      chk("midreset done pulses", bad_done, 0);
      chk("midreset busy", bad_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
